axi_master_wr: RTL and testbench
================================

Name: axi_master_wr

Overview:
AXI4 write-channel master for the action datapath. Local logic pushes write data into an internal buffer, then issues burst requests (address, beat count). The block drives AW and W, collects B responses, and limits the number of outstanding bursts. It reports FIFO and response errors on status/error, using the same layout as the read-side master.

Parameters:
ID_WIDTH, 1, AXI ID width
ADDR_WIDTH, 64, AXI address width
DATA_WIDTH, 64, AXI data width; one beat = DATA_WIDTH/8 bytes
AWUSER_WIDTH, 8, awuser width
MAX_WRREQ_NUM, 8, maximum outstanding bursts (power of 2, ≤16)
FIFO_DEPTH, 512, data buffer depth in beats (≥256)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
clear  in  1  sync flush of FIFOs, W FSM and error flags
i_snap_context  in  32  context; low AWUSER_WIDTH bits drive awuser
m_axi_awid/awaddr/awlen/awsize/awburst/awuser/awcache/awlock/awprot/awqos/awregion  out  AXI widths  AW payload
m_axi_awvalid  out  1 / m_axi_awready  in  1  AW handshake
m_axi_wdata  out  DATA_WIDTH / m_axi_wstrb  out  DATA_WIDTH/8 / m_axi_wlast  out  1  W payload
m_axi_wvalid  out  1 / m_axi_wready  in  1  W handshake
m_axi_bid  in  ID_WIDTH / m_axi_bresp  in  2 / m_axi_bvalid  in  1 / m_axi_bready  out  1  B channel
lcl_ibusy  out  1  request side busy; lcl_istart ignored while high
lcl_istart  in  1  burst request strobe
lcl_iaddr  in  ADDR_WIDTH  burst start byte address
lcl_inum  in  8  beats in burst; 0 means 256
lcl_irdy  out  1  data buffer can accept writes
lcl_den  in  1  data write strobe
lcl_din  in  DATA_WIDTH  write data
lcl_idone  out  1  one-cycle pulse when all outstanding bursts are responded
status  out  6  {lenq_empty, dfifo_empty, wrovfl, bunexp, wr_error[1:0]}
error  out  4  {wrovfl, bunexp, wr_error[1:0]}

Behaviour:
- Constant outputs:
  - awid=0, awsize=log2(DATA_WIDTH/8) (3 for 64b), awburst=INCR, awcache=4'd3.
  - awlock=0, awprot=0, awqos=0, awregion=0, wstrb all ones.
- Reset values:
  - All valids 0; awaddr, awlen, wdata 0; wlast 0; bready 0.
  - lcl_ibusy 0, lcl_irdy 0, lcl_idone 0, status 0, error 0.
  - bready and irdy go to 1 on the first clock after reset release.
- Accept: req_ok = lcl_istart & ~lcl_ibusy. On req_ok:
  - Register awaddr<=lcl_iaddr and awlen<=lcl_inum-1 (8-bit wrap, so inum=0 gives 255).
  - awvalid<=1 on the next edge; awvalid clears on the awready handshake.
  - awaddr/awlen are held stable while awvalid=1.
  - Push awlen into the length queue (depth MAX_WRREQ_NUM).
- lcl_ibusy (registered):
  - Set on req_ok.
  - Otherwise equals aw_hold | (wrreq_cnt ≥ MAX_WRREQ_NUM-1), where aw_hold spans req_ok through the AW handshake.
- wrreq_cnt (0..MAX_WRREQ_NUM):
  - +1 on req_ok without a B handshake.
  - -1 on a B handshake without req_ok.
  - Unchanged when both occur in the same cycle.
- W FSM:
  - IDLE: if the length queue is non-empty, pop it, load beat_cnt=len, go to DATA.
  - DATA: wvalid = ~dfifo_empty; wdata comes from the FIFO head (first-word-fall-through).
  - DATA: wlast=(beat_cnt==0). Each handshake pops the FIFO and decrements beat_cnt.
  - DATA: the last handshake returns to IDLE; the next burst may start on the following cycle.
  - W beats may precede the AW handshake.
  - wvalid never drops mid-beat once asserted without a handshake; payload is held stable until wready.
- Data FIFO:
  - lcl_den writes lcl_din.
  - lcl_irdy (registered) = count ≤ FIFO_DEPTH-16; local logic stops den within 8 cycles of irdy=0.
  - lcl_den while full: data dropped, wrovfl set (sticky).
- B channel:
  - bready stays 1.
  - A handshake with bresp≠0 latches wr_error<=bresp (sticky; the last nonzero value wins).
  - A handshake while wrreq_cnt==0 sets bunexp (sticky) and does not change the count.
- lcl_idone: one-cycle pulse on the edge where a B handshake takes wrreq_cnt 1→0 with no req_ok in the same cycle.
- clear:
  - Flushes the data FIFO and length queue; W FSM goes to IDLE with wvalid=0.
  - Clears wrovfl, bunexp and wr_error.
  - Does not alter wrreq_cnt, awvalid, awaddr or awlen.
  - Legal only with no W burst in progress.
- An async reset mid-operation returns every output to its reset value immediately; in-flight bursts are abandoned.

Test Plan:
1. Push 0x11,0x22,0x33,0x44; istart iaddr=0x1000 inum=4; awready=wready=1 → awaddr=0x1000, awlen=3, four beats in order, wlast on 0x44; bresp=0 → idone pulses once, error=0.
2. Push 256 words; istart inum=0 → awlen=255, 256 W beats, wlast only on beat 256.
3. bvalid held 0; issue eight 1-beat requests → ibusy stays 1 after the 7th accepted request, and further istarts produce no AW. Then return 7 B responses → wrreq_cnt=0, exactly one idone.
4. Second burst gets bresp=2'b10 → error=4'b0010 and it persists. Pulse clear → error=0.
5. awready held 0 for 10 cycles after istart → awvalid, awaddr, awlen stable and ibusy=1; a second istart is ignored, and only one AW is issued. In the same run, req_ok coincident with a B handshake leaves wrreq_cnt unchanged.
6. wready=0; push 513 words into the 512-deep FIFO → irdy low by 497 entries, error[3]=1. Then assert rst_n=0 mid-burst → all valids 0 and error=0 without a clock edge.

Source files
------------

// File: rtl/axi_master_wr.sv
// AXI4 write-channel master: buffers local write data, issues AW bursts on request,
// streams W beats from the buffer, collects B responses and bounds outstanding bursts.
module axi_master_wr #(
  parameter int ID_WIDTH      = 1,
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int AWUSER_WIDTH  = 8,
  parameter int MAX_WRREQ_NUM = 8,
  parameter int FIFO_DEPTH    = 512
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [31:0]               i_snap_context,
  output logic [ID_WIDTH-1:0]       m_axi_awid,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic [AWUSER_WIDTH-1:0]   m_axi_awuser,
  output logic [3:0]                m_axi_awcache,
  output logic                      m_axi_awlock,
  output logic [2:0]                m_axi_awprot,
  output logic [3:0]                m_axi_awqos,
  output logic [3:0]                m_axi_awregion,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [ID_WIDTH-1:0]       m_axi_bid,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic                      lcl_ibusy,
  input  logic                      lcl_istart,
  input  logic [ADDR_WIDTH-1:0]     lcl_iaddr,
  input  logic [7:0]                lcl_inum,
  output logic                      lcl_irdy,
  input  logic                      lcl_den,
  input  logic [DATA_WIDTH-1:0]     lcl_din,
  output logic                      lcl_idone,
  output logic [5:0]                status,
  output logic [3:0]                error
);

  localparam int FA = $clog2(FIFO_DEPTH);
  localparam int QA = $clog2(MAX_WRREQ_NUM);
  localparam int CW = QA + 1;
  localparam logic [FA:0]   DF_FULL    = (FA+1)'(FIFO_DEPTH);
  localparam logic [FA:0]   DF_IRDY_TH = (FA+1)'(FIFO_DEPTH - 16);
  localparam logic [FA-1:0] DF_LAST    = FA'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] BUSY_TH    = CW'(MAX_WRREQ_NUM - 1);

  typedef enum logic {W_IDLE, W_DATA} wstate_t;

  logic req_ok, aw_hs, w_hs, b_hs, b_counted;

  assign req_ok    = lcl_istart & ~lcl_ibusy;
  assign aw_hs     = m_axi_awvalid & m_axi_awready;
  assign w_hs      = m_axi_wvalid & m_axi_wready;
  assign b_hs      = m_axi_bvalid & m_axi_bready;

  assign m_axi_awid     = '0;
  assign m_axi_awsize   = 3'($clog2(DATA_WIDTH/8));
  assign m_axi_awburst  = 2'b01;
  assign m_axi_awuser   = i_snap_context[AWUSER_WIDTH-1:0];
  assign m_axi_awcache  = 4'd3;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awprot   = 3'd0;
  assign m_axi_awqos    = 4'd0;
  assign m_axi_awregion = 4'd0;
  assign m_axi_wstrb    = '1;

  logic unused_ok;
  assign unused_ok = ^{m_axi_bid, i_snap_context[31:AWUSER_WIDTH]};

  // Data FIFO (first-word-fall-through; depth need not be a power of 2)
  logic [DATA_WIDTH-1:0] dmem [FIFO_DEPTH];
  logic [FA-1:0]         dwr_ptr, drd_ptr;
  logic [FA:0]           dcnt;
  logic                  dfifo_empty, dfifo_full, dpush;

  assign dfifo_empty = (dcnt == '0);
  assign dfifo_full  = (dcnt == DF_FULL);
  assign dpush       = lcl_den & ~dfifo_full;

  function automatic logic [FA-1:0] dptr_next(input logic [FA-1:0] p);
    return (p == DF_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (dpush) dmem[dwr_ptr] <= lcl_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwr_ptr <= '0;
      drd_ptr <= '0;
      dcnt    <= '0;
    end else if (clear) begin
      dwr_ptr <= '0;
      drd_ptr <= '0;
      dcnt    <= '0;
    end else begin
      if (dpush) dwr_ptr <= dptr_next(dwr_ptr);
      if (w_hs)  drd_ptr <= dptr_next(drd_ptr);
      dcnt <= dcnt + (FA+1)'(dpush) - (FA+1)'(w_hs);
    end
  end

  // Length queue: one awlen per accepted request, consumed by the W FSM
  logic [7:0]    lq_mem [MAX_WRREQ_NUM];
  logic [QA-1:0] lq_wr_ptr, lq_rd_ptr;
  logic [CW-1:0] lq_cnt;
  logic          lenq_empty, lq_pop;

  assign lenq_empty = (lq_cnt == '0);

  always_ff @(posedge clk) begin
    if (req_ok) lq_mem[lq_wr_ptr] <= lcl_inum - 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lq_wr_ptr <= '0;
      lq_rd_ptr <= '0;
      lq_cnt    <= '0;
    end else if (clear) begin
      lq_wr_ptr <= '0;
      lq_rd_ptr <= '0;
      lq_cnt    <= '0;
    end else begin
      if (req_ok) lq_wr_ptr <= lq_wr_ptr + 1'b1;
      if (lq_pop) lq_rd_ptr <= lq_rd_ptr + 1'b1;
      lq_cnt <= lq_cnt + CW'(req_ok) - CW'(lq_pop);
    end
  end

  // W channel FSM
  wstate_t    wstate, wstate_nxt;
  logic [7:0] beat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wstate <= W_IDLE;
    else        wstate <= wstate_nxt;
  end

  always_comb begin
    wstate_nxt = wstate;
    lq_pop     = 1'b0;
    if (clear) begin
      wstate_nxt = W_IDLE;
    end else begin
      case (wstate)
        W_IDLE: if (!lenq_empty) begin
          lq_pop     = 1'b1;
          wstate_nxt = W_DATA;
        end
        W_DATA: if (w_hs && beat_cnt == 8'd0) wstate_nxt = W_IDLE;
        default: wstate_nxt = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      beat_cnt <= 8'd0;
    else if (lq_pop) beat_cnt <= lq_mem[lq_rd_ptr];
    else if (w_hs)   beat_cnt <= beat_cnt - 8'd1;
  end

  // wvalid only falls on a handshake: the FIFO head is popped solely by w_hs
  assign m_axi_wvalid = (wstate == W_DATA) & ~dfifo_empty;
  assign m_axi_wlast  = (wstate == W_DATA) & (beat_cnt == 8'd0);
  assign m_axi_wdata  = m_axi_wvalid ? dmem[drd_ptr] : '0;

  // AW channel and request-side control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= 8'd0;
    end else if (req_ok) begin
      m_axi_awvalid <= 1'b1;
      m_axi_awaddr  <= lcl_iaddr;
      m_axi_awlen   <= lcl_inum - 8'd1;
    end else if (aw_hs) begin
      m_axi_awvalid <= 1'b0;
    end
  end

  logic [CW-1:0] wrreq_cnt;
  logic          wrovfl, bunexp;
  logic [1:0]    wr_error;

  // A B beat with nothing outstanding is flagged, never counted
  assign b_counted = b_hs & (wrreq_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrreq_cnt    <= '0;
      lcl_ibusy    <= 1'b0;
      lcl_idone    <= 1'b0;
      lcl_irdy     <= 1'b0;
      m_axi_bready <= 1'b0;
    end else begin
      if (req_ok && !b_counted)      wrreq_cnt <= wrreq_cnt + 1'b1;
      else if (!req_ok && b_counted) wrreq_cnt <= wrreq_cnt - 1'b1;
      lcl_ibusy    <= req_ok | m_axi_awvalid | (wrreq_cnt >= BUSY_TH);
      lcl_idone    <= b_counted & ~req_ok & (wrreq_cnt == CW'(1));
      lcl_irdy     <= (dcnt <= DF_IRDY_TH);
      m_axi_bready <= 1'b1;
    end
  end

  // Sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrovfl   <= 1'b0;
      bunexp   <= 1'b0;
      wr_error <= 2'b00;
    end else if (clear) begin
      wrovfl   <= 1'b0;
      bunexp   <= 1'b0;
      wr_error <= 2'b00;
    end else begin
      if (lcl_den && dfifo_full)          wrovfl   <= 1'b1;
      if (b_hs && wrreq_cnt == '0)        bunexp   <= 1'b1;
      if (b_hs && m_axi_bresp != 2'b00)   wr_error <= m_axi_bresp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status <= 6'd0;
    else        status <= {lenq_empty, dfifo_empty, wrovfl, bunexp, wr_error};
  end

  assign error = {wrovfl, bunexp, wr_error};

endmodule

// File: tb/tb_axi_master_wr.sv
// Directed scoreboard bench for axi_master_wr: stimulus queues expected AW/W
// transfers, a negedge monitor pops and compares them as the DUT hands them over.
module tb_axi_master_wr;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clear;
  logic [31:0] ctx;
  logic [0:0]  awid;
  logic [63:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [7:0]  awuser;
  logic [3:0]  awcache;
  logic        awlock;
  logic [2:0]  awprot;
  logic [3:0]  awqos, awregion;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [0:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        ibusy, istart;
  logic [63:0] iaddr;
  logic [7:0]  inum;
  logic        irdy, den;
  logic [63:0] din;
  logic        idone;
  logic [5:0]  status;
  logic [3:0]  error;

  axi_master_wr #(
    .ID_WIDTH(1), .ADDR_WIDTH(64), .DATA_WIDTH(64), .AWUSER_WIDTH(8),
    .MAX_WRREQ_NUM(8), .FIFO_DEPTH(512)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .i_snap_context(ctx),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awuser(awuser),
    .m_axi_awcache(awcache), .m_axi_awlock(awlock), .m_axi_awprot(awprot),
    .m_axi_awqos(awqos), .m_axi_awregion(awregion),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .lcl_ibusy(ibusy), .lcl_istart(istart), .lcl_iaddr(iaddr), .lcl_inum(inum),
    .lcl_irdy(irdy), .lcl_den(den), .lcl_din(din), .lcl_idone(idone),
    .status(status), .error(error)
  );

  typedef struct packed { logic [63:0] addr; logic [7:0] len; } aw_t;
  typedef struct packed { logic [63:0] data; logic last; } w_t;

  aw_t         exp_aw[$];
  w_t          exp_w[$];
  logic [63:0] dmodel[$];
  aw_t         mon_aw;
  w_t          mon_w;
  int          tests = 0;
  int          fails = 0;
  int          idone_cnt = 0;
  int          base;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every AW / W handshake against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (idone) idone_cnt++;
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) begin
          tests++; fails++;
          $display("FAIL aw_unexpected: got addr 0x%0h len %0d, expected no AW", awaddr, awlen);
        end else begin
          mon_aw = exp_aw.pop_front();
          chk("aw_addr", awaddr, mon_aw.addr);
          chk("aw_len", awlen, mon_aw.len);
        end
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) begin
          tests++; fails++;
          $display("FAIL w_unexpected: got data 0x%0h last %0b, expected no W", wdata, wlast);
        end else begin
          mon_w = exp_w.pop_front();
          chk("w_data", wdata, mon_w.data);
          chk("w_last", wlast, mon_w.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [63:0] d);
    den = 1'b1; din = d;
    tick();
    den = 1'b0;
    dmodel.push_back(d);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (ibusy && n < 100) begin tick(); n++; end
    chk(name, ibusy, 0);
  endtask

  task automatic expect_burst(input logic [63:0] addr, input int beats);
    aw_t a;
    w_t  w;
    a.addr = addr; a.len = 8'(beats - 1);
    exp_aw.push_back(a);
    for (int i = 0; i < beats; i++) begin
      w.data = dmodel.pop_front();
      w.last = (i == beats - 1);
      exp_w.push_back(w);
    end
  endtask

  task automatic req(input logic [63:0] addr, input int beats, input string name);
    wait_idle(name);
    expect_burst(addr, beats);
    istart = 1'b1; iaddr = addr; inum = 8'(beats);
    tick();
    istart = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] resp);
    bvalid = 1'b1; bresp = resp;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_aw.size() + exp_w.size()) != 0 && n < budget) begin tick(); n++; end
    chk(name, exp_aw.size() + exp_w.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; ctx = 32'hA5A5_5A3C;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = 2'b00; bvalid = 1'b0;
    istart = 1'b0; iaddr = '0; inum = '0; den = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_ibusy", ibusy, 0);
    chk("rst_irdy", irdy, 0);
    chk("rst_idone", idone, 0);
    chk("rst_status", status, 0);
    chk("rst_error", error, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_awlen", awlen, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wlast", wlast, 0);
    chk("const_awsize", awsize, 3);
    chk("const_awburst", awburst, 1);
    chk("const_awcache", awcache, 3);
    chk("const_awuser", awuser, 8'h3C);
    chk("const_wstrb", wstrb, 8'hFF);
    chk("const_awid", awid, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_bready", bready, 1);
    chk("post_rst_irdy", irdy, 1);

    // 1: four-beat burst
    awready = 1'b1; wready = 1'b1;
    base = idone_cnt;
    push_word(64'h11); push_word(64'h22); push_word(64'h33); push_word(64'h44);
    req(64'h1000, 4, "t1_idle");
    drain("t1_drain", 50);
    send_b(2'b00);
    repeat (3) tick();
    chk("t1_idone", idone_cnt - base, 1);
    chk("t1_error", error, 0);
    chk("t1_status", status, 6'b110000);

    // 2: 256-beat burst (inum = 0)
    base = idone_cnt;
    for (int i = 0; i < 256; i++) push_word(64'hB000_0000_0000_0000 + 64'(i));
    req(64'h2000, 256, "t2_idle");
    drain("t2_drain", 700);
    send_b(2'b00);
    repeat (3) tick();
    chk("t2_idone", idone_cnt - base, 1);

    // 3: outstanding limit, then B returns, then an unexpected B
    base = idone_cnt;
    for (int i = 0; i < 7; i++) push_word(64'hC0 + 64'(i));
    for (int k = 0; k < 7; k++) req(64'h3000 + 64'(k * 64), 1, "t3_idle");
    repeat (2) tick();
    chk("t3_busy_after7", ibusy, 1);
    istart = 1'b1; iaddr = 64'h3800; inum = 8'd1;
    repeat (3) tick();
    istart = 1'b0;
    chk("t3_busy_still", ibusy, 1);
    drain("t3_drain", 100);
    repeat (5) tick();
    for (int k = 0; k < 7; k++) send_b(2'b00);
    repeat (2) tick();
    chk("t3_idone", idone_cnt - base, 1);
    chk("t3_not_busy", ibusy, 0);
    send_b(2'b00);
    tick();
    chk("t3_bunexp", error, 4'b0100);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t3_clear", error, 0);

    // 4: error response on the second burst
    base = idone_cnt;
    for (int i = 0; i < 4; i++) push_word(64'hD0 + 64'(i));
    req(64'h4000, 2, "t4_idle_a");
    req(64'h4100, 2, "t4_idle_b");
    drain("t4_drain", 50);
    send_b(2'b00);
    tick();
    send_b(2'b10);
    repeat (2) tick();
    chk("t4_error", error, 4'b0010);
    repeat (5) tick();
    chk("t4_error_sticky", error, 4'b0010);
    chk("t4_idone", idone_cnt - base, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t4_clear", error, 0);

    // 5: AW back-pressure, then req_ok coincident with a B handshake
    awready = 1'b0;
    base = idone_cnt;
    push_word(64'h55);
    req(64'h5000, 1, "t5_idle");
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin istart = 1'b1; iaddr = 64'h5800; inum = 8'd4; end
      tick();
      istart = 1'b0;
      chk("t5_awvalid", awvalid, 1);
      chk("t5_awaddr", awaddr, 64'h5000);
      chk("t5_awlen", awlen, 0);
      chk("t5_ibusy", ibusy, 1);
    end
    awready = 1'b1;
    drain("t5_drain_a", 20);
    wait_idle("t5_idle_b");
    push_word(64'h66);
    expect_burst(64'h6000, 1);
    istart = 1'b1; iaddr = 64'h6000; inum = 8'd1;
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    istart = 1'b0; bvalid = 1'b0;
    repeat (2) tick();
    chk("t5_no_idone", idone_cnt - base, 0);
    drain("t5_drain_b", 20);
    send_b(2'b00);
    repeat (2) tick();
    chk("t5_idone", idone_cnt - base, 1);
    chk("t5_error", error, 0);

    // 6: FIFO overflow, then async reset mid-burst
    wready = 1'b0;
    for (int i = 0; i < 513; i++) begin
      den = 1'b1; din = 64'hE000 + 64'(i);
      tick();
      if (i == 489) chk("t6_irdy_high", irdy, 1);
      if (i == 497) chk("t6_irdy_low", irdy, 0);
    end
    den = 1'b0;
    tick();
    chk("t6_wrovfl", error, 4'b1000);
    chk("t6_status", status, 6'b101000);
    awready = 1'b0;
    wait_idle("t6_idle");
    istart = 1'b1; iaddr = 64'h7000; inum = 8'd4;
    tick();
    istart = 1'b0;
    repeat (3) tick();
    chk("t6_pre_awvalid", awvalid, 1);
    chk("t6_pre_wvalid", wvalid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_awvalid", awvalid, 0);
    chk("t6_rst_wvalid", wvalid, 0);
    chk("t6_rst_error", error, 0);
    chk("t6_rst_ibusy", ibusy, 0);
    chk("t6_rst_irdy", irdy, 0);
    chk("t6_rst_bready", bready, 0);
    chk("t6_rst_status", status, 0);
    chk("t6_rst_wlast", wlast, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("t6_post_irdy", irdy, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
